// File: rtl/apb_pkg.sv
// Shared APB types: bus widths, requester FSM state encoding and the command bundle
// used by the bridge and driver layers.
package apb_pkg;

  localparam int unsigned ADDR_WIDTH = 32;
  localparam int unsigned DATA_WIDTH = 32;

  typedef enum logic [1:0] {
    MST_IDLE   = 2'd0,
    MST_SETUP  = 2'd1,
    MST_ACCESS = 2'd2,
    MST_RESP   = 2'd3
  } apb_master_state_t;

  typedef struct packed {
    logic                  write;
    logic [ADDR_WIDTH-1:0] addr;
    logic [DATA_WIDTH-1:0] wdata;
  } apb_cmd_t;

endpackage

// File: rtl/apb_master_wdog.sv
// ACCESS-phase wait counter for apb_master_ctrl: cleared before each ACCESS phase,
// counts cycles without completion, flags expiry at TIMEOUT_CYCLES-1.
module apb_master_wdog #(
  parameter int unsigned TIMEOUT_CYCLES = 16
) (
  input  logic i_clk,
  input  logic i_rst_n,
  input  logic i_clear,
  input  logic i_inc,
  output logic o_expire
);

  localparam int unsigned CW = $clog2(TIMEOUT_CYCLES + 1);
  localparam logic [CW-1:0] LIMIT = CW'(TIMEOUT_CYCLES - 1);

  logic [CW-1:0] r_count;

  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      r_count <= '0;
    end else if (i_clear) begin
      r_count <= '0;
    end else if (i_inc) begin
      r_count <= r_count + CW'(1);
    end
  end

  assign o_expire = (r_count == LIMIT);

endmodule

// File: rtl/apb_master_ctrl.sv
// Single-outstanding APB requester: cmd valid/ready in, SETUP/ACCESS on the bus, rsp valid/ready out.
// Optional ACCESS-phase timeout enabled by defining APB_MASTER_TIMEOUT_EN.
module apb_master_ctrl
  import apb_pkg::*;
#(
  parameter int unsigned ADDR_WIDTH     = apb_pkg::ADDR_WIDTH,
  parameter int unsigned DATA_WIDTH     = apb_pkg::DATA_WIDTH,
  parameter int unsigned TIMEOUT_CYCLES = 16
) (
  input  logic                  pclk,
  input  logic                  presetn,
  input  logic                  cmd_valid,
  output logic                  cmd_ready,
  input  logic                  cmd_write,
  input  logic [ADDR_WIDTH-1:0] cmd_addr,
  input  logic [DATA_WIDTH-1:0] cmd_wdata,
  output logic                  rsp_valid,
  input  logic                  rsp_ready,
  output logic [DATA_WIDTH-1:0] rsp_rdata,
  output logic                  rsp_err,
  output logic                  rsp_timeout,
  output logic                  busy,
  output logic                  psel,
  output logic                  penable,
  output logic                  pwrite,
  output logic [ADDR_WIDTH-1:0] paddr,
  output logic [DATA_WIDTH-1:0] pwdata,
  input  logic [DATA_WIDTH-1:0] prdata,
  input  logic                  pready,
  input  logic                  pslverr
);

  apb_master_state_t r_state, w_state_nxt;

  logic                  r_psel, w_psel_nxt;
  logic                  r_penable, w_penable_nxt;
  logic                  r_pwrite, w_pwrite_nxt;
  logic [ADDR_WIDTH-1:0] r_paddr, w_paddr_nxt;
  logic [DATA_WIDTH-1:0] r_pwdata, w_pwdata_nxt;
  logic                  r_rsp_valid, w_rsp_valid_nxt;
  logic [DATA_WIDTH-1:0] r_rsp_rdata, w_rsp_rdata_nxt;
  logic                  r_rsp_err, w_rsp_err_nxt;
  logic                  r_rsp_timeout, w_rsp_timeout_nxt;

  logic w_complete;
  logic w_expire;

  // The team slave raises pslverr without pready, so either one ends ACCESS.
  assign w_complete = pready | pslverr;

`ifdef APB_MASTER_TIMEOUT_EN
  logic w_wd_expire;

  apb_master_wdog #(
    .TIMEOUT_CYCLES (TIMEOUT_CYCLES)
  ) u_wdog (
    .i_clk    (pclk),
    .i_rst_n  (presetn),
    .i_clear  (r_state == MST_SETUP),
    .i_inc    ((r_state == MST_ACCESS) && !w_complete),
    .o_expire (w_wd_expire)
  );

  assign w_expire = w_wd_expire;
`else
  logic w_unused_timeout_cfg;

  assign w_unused_timeout_cfg = ^TIMEOUT_CYCLES;
  assign w_expire             = 1'b0;
`endif

  always_comb begin
    w_state_nxt       = r_state;
    w_psel_nxt        = r_psel;
    w_penable_nxt     = r_penable;
    w_pwrite_nxt      = r_pwrite;
    w_paddr_nxt       = r_paddr;
    w_pwdata_nxt      = r_pwdata;
    w_rsp_valid_nxt   = r_rsp_valid;
    w_rsp_rdata_nxt   = r_rsp_rdata;
    w_rsp_err_nxt     = r_rsp_err;
    w_rsp_timeout_nxt = r_rsp_timeout;

    case (r_state)
      MST_IDLE: begin
        w_psel_nxt    = 1'b0;
        w_penable_nxt = 1'b0;
        if (cmd_valid) begin
          w_pwrite_nxt = cmd_write;
          w_paddr_nxt  = cmd_addr;
          w_pwdata_nxt = cmd_wdata;
          w_psel_nxt   = 1'b1;
          w_state_nxt  = MST_SETUP;
        end
      end

      MST_SETUP: begin
        w_psel_nxt    = 1'b1;
        w_penable_nxt = 1'b1;
        w_state_nxt   = MST_ACCESS;
      end

      MST_ACCESS: begin
        // Completion has priority over a same-edge timeout.
        if (w_complete) begin
          w_psel_nxt        = 1'b0;
          w_penable_nxt     = 1'b0;
          w_rsp_valid_nxt   = 1'b1;
          w_rsp_err_nxt     = pslverr;
          w_rsp_timeout_nxt = 1'b0;
          w_rsp_rdata_nxt   = (!r_pwrite && !pslverr) ? prdata : '0;
          w_state_nxt       = MST_RESP;
        end else if (w_expire) begin
          w_psel_nxt        = 1'b0;
          w_penable_nxt     = 1'b0;
          w_rsp_valid_nxt   = 1'b1;
          w_rsp_err_nxt     = 1'b1;
          w_rsp_timeout_nxt = 1'b1;
          w_rsp_rdata_nxt   = '0;
          w_state_nxt       = MST_RESP;
        end
      end

      MST_RESP: begin
        if (rsp_ready) begin
          w_rsp_valid_nxt = 1'b0;
          w_state_nxt     = MST_IDLE;
        end
      end

      default: begin
        w_psel_nxt      = 1'b0;
        w_penable_nxt   = 1'b0;
        w_rsp_valid_nxt = 1'b0;
        w_state_nxt     = MST_IDLE;
      end
    endcase
  end

  always_ff @(posedge pclk or negedge presetn) begin
    if (!presetn) begin
      r_state <= MST_IDLE;
    end else begin
      r_state <= w_state_nxt;
    end
  end

  always_ff @(posedge pclk or negedge presetn) begin
    if (!presetn) begin
      r_psel        <= 1'b0;
      r_penable     <= 1'b0;
      r_pwrite      <= 1'b0;
      r_paddr       <= '0;
      r_pwdata      <= '0;
      r_rsp_valid   <= 1'b0;
      r_rsp_rdata   <= '0;
      r_rsp_err     <= 1'b0;
      r_rsp_timeout <= 1'b0;
    end else begin
      r_psel        <= w_psel_nxt;
      r_penable     <= w_penable_nxt;
      r_pwrite      <= w_pwrite_nxt;
      r_paddr       <= w_paddr_nxt;
      r_pwdata      <= w_pwdata_nxt;
      r_rsp_valid   <= w_rsp_valid_nxt;
      r_rsp_rdata   <= w_rsp_rdata_nxt;
      r_rsp_err     <= w_rsp_err_nxt;
      r_rsp_timeout <= w_rsp_timeout_nxt;
    end
  end

  assign cmd_ready   = (r_state == MST_IDLE);
  assign busy        = (r_state != MST_IDLE);
  assign psel        = r_psel;
  assign penable     = r_penable;
  assign pwrite      = r_pwrite;
  assign paddr       = r_paddr;
  assign pwdata      = r_pwdata;
  assign rsp_valid   = r_rsp_valid;
  assign rsp_rdata   = r_rsp_rdata;
  assign rsp_err     = r_rsp_err;
  assign rsp_timeout = r_rsp_timeout;

endmodule

// File: tb/tb_apb_master_ctrl.sv
// Scoreboard bench for apb_master_ctrl: directed commands push expected responses,
// a monitor pops them on each response handshake; a simple APB slave model drives pready/pslverr.
`timescale 1ns/1ps
module tb_apb_master_ctrl;

  logic        pclk = 1'b0;
  logic        presetn;
  logic        cmd_valid;
  logic        cmd_ready;
  logic        cmd_write;
  logic [31:0] cmd_addr;
  logic [31:0] cmd_wdata;
  logic        rsp_valid;
  logic        rsp_ready;
  logic [31:0] rsp_rdata;
  logic        rsp_err;
  logic        rsp_timeout;
  logic        busy;
  logic        psel;
  logic        penable;
  logic        pwrite;
  logic [31:0] paddr;
  logic [31:0] pwdata;
  logic [31:0] prdata;
  logic        pready;
  logic        pslverr;

  apb_master_ctrl #(
    .ADDR_WIDTH     (32),
    .DATA_WIDTH     (32),
    .TIMEOUT_CYCLES (16)
  ) dut (
    .pclk        (pclk),
    .presetn     (presetn),
    .cmd_valid   (cmd_valid),
    .cmd_ready   (cmd_ready),
    .cmd_write   (cmd_write),
    .cmd_addr    (cmd_addr),
    .cmd_wdata   (cmd_wdata),
    .rsp_valid   (rsp_valid),
    .rsp_ready   (rsp_ready),
    .rsp_rdata   (rsp_rdata),
    .rsp_err     (rsp_err),
    .rsp_timeout (rsp_timeout),
    .busy        (busy),
    .psel        (psel),
    .penable     (penable),
    .pwrite      (pwrite),
    .paddr       (paddr),
    .pwdata      (pwdata),
    .prdata      (prdata),
    .pready      (pready),
    .pslverr     (pslverr)
  );

  always #5 pclk = ~pclk;

  typedef struct {
    logic [31:0] rdata;
    logic        err;
    logic        to;
  } rsp_t;

  rsp_t exp_q[$];
  int   n_checks  = 0;
  int   n_err     = 0;
  int   n_rsp     = 0;
  int   exp_total = 0;

  // Expected APB request fields while psel is high
  logic [31:0] exp_addr  = '0;
  logic        exp_write = 1'b0;
  logic [31:0] exp_wdata = '0;
  int          psel_cnt  = 0;
  int          pen_cnt   = 0;

  // Slave model configuration
  int          sl_wait  = 0;
  logic        sl_err   = 1'b0;
  logic        sl_stall = 1'b0;
  logic [31:0] sl_rdata = '0;
  int          acc_n    = 0;

  task automatic check(input string name, input logic [63:0] got, input logic [63:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h at %0t", name, got, exp, $time);
    end
  endtask

  // Response monitor / scoreboard
  always begin : rsp_mon
    rsp_t e;
    @(negedge pclk);
    #2;
    if (presetn && rsp_valid && rsp_ready) begin
      if (exp_q.size() == 0) begin
        n_checks++;
        n_err++;
        $display("FAIL unexpected_rsp: got rdata=0x%0h err=%0b, expected no response", rsp_rdata, rsp_err);
      end else begin
        e = exp_q.pop_front();
        check("rsp_rdata", rsp_rdata, e.rdata);
        check("rsp_err", rsp_err, e.err);
        check("rsp_timeout", rsp_timeout, e.to);
        n_rsp++;
      end
    end
  end

  // APB request monitor: fields must match the issued command for every psel cycle
  always begin : apb_mon
    @(negedge pclk);
    #2;
    if (presetn && psel) begin
      psel_cnt++;
      check("paddr", paddr, exp_addr);
      check("pwrite", pwrite, exp_write);
      check("pwdata", pwdata, exp_wdata);
    end
    if (presetn && penable) pen_cnt++;
  end

  // APB slave model: completes after sl_wait wait states
  always @(negedge pclk) begin : slave
    logic done;
    if (psel && penable) acc_n++;
    else acc_n = 0;
    done    = psel && penable && !sl_stall && (acc_n == sl_wait + 1);
    pready  = done && !sl_err;
    pslverr = done && sl_err;
    prdata  = done ? sl_rdata : 32'hA5A5_A5A5;
  end

  task automatic issue(input logic w, input logic [31:0] a, input logic [31:0] d,
                       input logic [31:0] er, input logic ee, input logic et);
    int n;
    rsp_t r;
    exp_addr  = a;
    exp_write = w;
    exp_wdata = d;
    r.rdata = er;
    r.err   = ee;
    r.to    = et;
    exp_q.push_back(r);
    exp_total++;
    cmd_valid = 1'b1;
    cmd_write = w;
    cmd_addr  = a;
    cmd_wdata = d;
    n = 0;
    while (!cmd_ready && n < 50) begin
      @(negedge pclk);
      n++;
    end
    check("cmd_accept_wait", cmd_ready, 1'b1);
    @(negedge pclk);
    cmd_valid = 1'b0;
  endtask

  task automatic wait_rsp();
    int n;
    n = 0;
    while (n_rsp < exp_total && n < 100) begin
      @(negedge pclk);
      #3;
      n++;
    end
    check("rsp_arrival", n_rsp, exp_total);
    @(negedge pclk);
    check("idle_after_rsp", busy, 1'b0);
  endtask

  task automatic clr_cnt();
    psel_cnt = 0;
    pen_cnt  = 0;
  endtask

  initial begin
    #100000;
    $display("FAIL global_timeout: simulation did not finish");
    $fatal(1, "global timeout");
  end

  initial begin
    int n;
    presetn   = 1'b0;
    cmd_valid = 1'b0;
    cmd_write = 1'b0;
    cmd_addr  = '0;
    cmd_wdata = '0;
    rsp_ready = 1'b1;
    repeat (2) @(negedge pclk);

    // Reset state
    check("rst_psel", psel, 1'b0);
    check("rst_penable", penable, 1'b0);
    check("rst_pwrite", pwrite, 1'b0);
    check("rst_paddr", paddr, 32'h0);
    check("rst_pwdata", pwdata, 32'h0);
    check("rst_rsp_valid", rsp_valid, 1'b0);
    check("rst_rsp_rdata", rsp_rdata, 32'h0);
    check("rst_rsp_err", rsp_err, 1'b0);
    check("rst_rsp_timeout", rsp_timeout, 1'b0);
    check("rst_busy", busy, 1'b0);
    check("rst_cmd_ready", cmd_ready, 1'b1);
    presetn = 1'b1;
    @(negedge pclk);

    // Write, zero wait states
    clr_cnt();
    sl_wait = 0; sl_err = 1'b0; sl_rdata = 32'h0;
    issue(1'b1, 32'h3, 32'hDEADBEEF, 32'h0, 1'b0, 1'b0);
    wait_rsp();
    check("wr_psel_cycles", psel_cnt, 2);
    check("wr_penable_cycles", pen_cnt, 1);

    // Read, three wait states
    clr_cnt();
    sl_wait = 3; sl_rdata = 32'hDEADBEEF;
    issue(1'b0, 32'h3, 32'h0, 32'hDEADBEEF, 1'b0, 1'b0);
    wait_rsp();
    check("rd_psel_cycles", psel_cnt, 5);
    check("rd_penable_cycles", pen_cnt, 4);

    // Write error: pslverr without pready
    clr_cnt();
    sl_wait = 0; sl_err = 1'b1;
    issue(1'b1, 32'h3, 32'h0, 32'h0, 1'b1, 1'b0);
    wait_rsp();
    check("err_penable_cycles", pen_cnt, 1);

    // Read error: data must be zeroed
    sl_rdata = 32'h11223344;
    issue(1'b0, 32'h10, 32'h0, 32'h0, 1'b1, 1'b0);
    wait_rsp();

    // Read, one wait state
    clr_cnt();
    sl_err = 1'b0; sl_wait = 1; sl_rdata = 32'hCAFEF00D;
    issue(1'b0, 32'h1C, 32'h77, 32'hCAFEF00D, 1'b0, 1'b0);
    wait_rsp();
    check("rd1_penable_cycles", pen_cnt, 2);

    // Response backpressure with next command pending
    sl_wait = 0; sl_rdata = 32'h12345678;
    rsp_ready = 1'b0;
    issue(1'b0, 32'h20, 32'h0, 32'h12345678, 1'b0, 1'b0);
    cmd_valid = 1'b1; cmd_write = 1'b1; cmd_addr = 32'h24; cmd_wdata = 32'h55AA55AA;
    n = 0;
    while (!rsp_valid && n < 20) begin
      @(negedge pclk);
      n++;
    end
    check("bp_rsp_valid_seen", rsp_valid, 1'b1);
    for (int i = 0; i < 5; i++) begin
      check("bp_cmd_ready", cmd_ready, 1'b0);
      check("bp_rsp_valid", rsp_valid, 1'b1);
      check("bp_rsp_rdata", rsp_rdata, 32'h12345678);
      check("bp_rsp_err", rsp_err, 1'b0);
      @(negedge pclk);
    end
    begin
      rsp_t r;
      r.rdata = 32'h0; r.err = 1'b0; r.to = 1'b0;
      exp_q.push_back(r);
      exp_total++;
    end
    exp_addr = 32'h24; exp_write = 1'b1; exp_wdata = 32'h55AA55AA;
    rsp_ready = 1'b1;
    @(negedge pclk);
    check("bp_accept_ready", cmd_ready, 1'b1);
    check("bp_rsp_dropped", rsp_valid, 1'b0);
    @(negedge pclk);
    check("bp_accepted_busy", busy, 1'b1);
    cmd_valid = 1'b0;
    wait_rsp();

    // Reset during ACCESS
    sl_stall = 1'b1;
    exp_addr = 32'h30; exp_write = 1'b0; exp_wdata = 32'h0;
    cmd_valid = 1'b1; cmd_write = 1'b0; cmd_addr = 32'h30; cmd_wdata = 32'h0;
    @(negedge pclk);
    cmd_valid = 1'b0;
    @(negedge pclk);
    check("mid_access_penable", penable, 1'b1);
    #1;
    presetn = 1'b0;
    #1;
    check("arst_psel", psel, 1'b0);
    check("arst_penable", penable, 1'b0);
    check("arst_busy", busy, 1'b0);
    check("arst_rsp_valid", rsp_valid, 1'b0);
    @(negedge pclk);
    presetn  = 1'b1;
    sl_stall = 1'b0;
    for (int i = 0; i < 3; i++) begin
      check("post_rst_cmd_ready", cmd_ready, 1'b1);
      check("post_rst_rsp_valid", rsp_valid, 1'b0);
      @(negedge pclk);
    end

`ifdef APB_MASTER_TIMEOUT_EN
    // Stuck slave aborts after TIMEOUT_CYCLES ACCESS cycles
    clr_cnt();
    sl_stall = 1'b1;
    issue(1'b0, 32'h40, 32'h0, 32'h0, 1'b1, 1'b1);
    wait_rsp();
    check("to_penable_cycles", pen_cnt, 16);
    sl_stall = 1'b0;

    // Completion on the threshold cycle wins
    clr_cnt();
    sl_wait = 15; sl_rdata = 32'h0F0F0F0F;
    issue(1'b0, 32'h44, 32'h0, 32'h0F0F0F0F, 1'b0, 1'b0);
    wait_rsp();
    check("to_edge_penable_cycles", pen_cnt, 16);
`endif

    check("scoreboard_empty", exp_q.size(), 0);
    $display("Result: errors=%0d of %0d checks", n_err, n_checks);
    $finish;
  end

endmodule

// File: doc/apb_master_ctrl.md
Name: apb_master_ctrl

Overview:
- Single-outstanding APB requester that sits directly upstream of apb_slave_top.
- Accepts read/write commands over a valid/ready interface and runs the APB SETUP→ACCESS protocol on psel/penable/paddr/pwrite/pwdata.
- Waits for slave completion, then returns read data and error status over a valid/ready response interface.
- Used by the bus bridge and testbench driver layers.

Parameters:
- ADDR_WIDTH, apb_pkg::ADDR_WIDTH, APB address width.
- DATA_WIDTH, apb_pkg::DATA_WIDTH, APB data width.
- TIMEOUT_CYCLES, 16, maximum ACCESS-phase cycles before abort (used only with APB_MASTER_TIMEOUT_EN).

Ports:
- pclk  in  1  APB clock, all logic rising-edge.
- presetn  in  1  asynchronous active-low reset.
- cmd_valid  in  1  command request.
- cmd_ready  out  1  command accepted when cmd_valid && cmd_ready.
- cmd_write  in  1  1=write, 0=read.
- cmd_addr  in  ADDR_WIDTH  target address.
- cmd_wdata  in  DATA_WIDTH  write data.
- rsp_valid  out  1  response available.
- rsp_ready  in  1  response consumed when rsp_valid && rsp_ready.
- rsp_rdata  out  DATA_WIDTH  read data; 0 for writes.
- rsp_err  out  1  slave error or timeout.
- rsp_timeout  out  1  timeout flag; tied 0 when the feature is absent.
- busy  out  1  high in any state other than IDLE.
- psel, penable, pwrite  out  1  APB controls.
- paddr  out  ADDR_WIDTH  APB address.
- pwdata  out  DATA_WIDTH  APB write data.
- prdata  in  DATA_WIDTH  APB read data.
- pready, pslverr  in  1  APB completion and error.

Behaviour:
- States (apb_master_state_t): MST_IDLE, MST_SETUP, MST_ACCESS, MST_RESP. Reset state is MST_IDLE.
- Reset values: psel=0, penable=0, pwrite=0, paddr=0, pwdata=0, rsp_valid=0, rsp_rdata=0, rsp_err=0, rsp_timeout=0, busy=0. cmd_ready=1, since it is decoded from state==MST_IDLE.
- Reset asserted mid-transfer drops all outputs to these values immediately, with no completion response.
- All APB outputs and rsp_* outputs are registered. cmd_ready and busy are decoded from the state register.
- MST_IDLE: on accept, latch cmd_write/cmd_addr/cmd_wdata into pwrite/paddr/pwdata, set psel=1, go to MST_SETUP. Without a valid command, stay; psel=0.
- MST_SETUP (exactly 1 cycle): psel=1, penable=0. Next edge sets penable=1 and goes to MST_ACCESS.
- MST_ACCESS: psel=1 and penable=1. paddr, pwrite and pwdata are held stable.
- Completion is sampled each edge as pready || pslverr. The team slave flags errors without pready, so pslverr alone completes the transfer.
- On completion:
  - rsp_err = pslverr.
  - rsp_rdata = prdata if read && !pslverr, otherwise 0.
  - rsp_valid=1; psel=0 and penable=0 on the same edge.
  - Go to MST_RESP.
- Otherwise the transfer stays in MST_ACCESS; wait states are unlimited unless the timeout feature is on.
- MST_RESP: rsp_* held stable while rsp_valid && !rsp_ready. On handshake, rsp_valid=0 and go to MST_IDLE.
- Minimum command-to-response latency is 3 edges (accept, SETUP→ACCESS, completion).
- The next command can be accepted the cycle after the response handshake.
- paddr/pwdata keep their last values in MST_IDLE; there is no requirement to zero them.
- pwrite/paddr/pwdata never change while psel=1.

Optional Feature:
- Macro: APB_MASTER_TIMEOUT_EN.
- Defined:
  - A wait counter of $clog2(TIMEOUT_CYCLES+1) bits clears on entry to MST_ACCESS and increments each ACCESS cycle without completion.
  - At count == TIMEOUT_CYCLES-1 with no completion: abort (psel=0, penable=0), rsp_err=1, rsp_timeout=1, rsp_rdata=0, go to MST_RESP.
  - If completion and the timeout threshold occur on the same edge, completion wins and rsp_timeout=0.
- Undefined: no counter; rsp_timeout constant 0; ACCESS waits indefinitely.

Decomposition:
- apb_pkg gains apb_master_state_t (MST_IDLE/MST_SETUP/MST_ACCESS/MST_RESP) and a packed apb_cmd_t {write, addr, wdata}. ADDR_WIDTH/DATA_WIDTH are reused from apb_pkg.
- Natural sub-module: apb_master_wdog (timeout counter, start/clear/expire), instantiated only under APB_MASTER_TIMEOUT_EN.

Test Plan:
- Write addr 0x3, data 0xDEADBEEF, pready=1 on first ACCESS → psel high 2 cycles, penable high 1 cycle; rsp_valid with rsp_err=0, rsp_rdata=0.
- Read addr 0x3, slave returns 0xDEADBEEF after 3 wait states → penable high 4 cycles; rsp_rdata=0xDEADBEEF; paddr stable throughout.
- Write pwdata=0 to apb_slave_top (pslverr=1, pready=0) → completes in 1 ACCESS cycle; rsp_err=1.
- Hold rsp_ready=0 for 5 cycles with cmd_valid asserted → cmd_ready=0 and rsp_* stable; accept occurs the cycle after rsp_ready=1.
- presetn low during MST_ACCESS → psel/penable 0 immediately, no rsp_valid, cmd_ready=1 after release.
- APB_MASTER_TIMEOUT_EN, TIMEOUT_CYCLES=16, pready stuck 0 → abort after 16 ACCESS cycles with rsp_err=1 and rsp_timeout=1; pready rising on cycle 16 → normal completion with rsp_timeout=0.
